// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parameterisable VGA raster timing generator. Walks an x/y position across
//   H_TOTAL x V_TOTAL pixel slots, advancing once per pixel clock-enable, and
//   produces sync, blanking and start-of-line/frame markers for that pixel.
//   Horizontal and vertical phases are tracked by two small 4-state FSMs.
//
// Ports
//   clk_i          system clock, all logic on rising edge
//   reset          asynchronous reset, active low
//   pix_ce_i       pixel clock-enable (from divider), synchronous to clk_i
//   hsync_o        horizontal sync, active low
//   vsync_o        vertical sync, active low
//   active_o       current pixel lies in the visible area
//   x_o, y_o       current pixel / line position
//   line_start_o   one-clk pulse when the new pixel has x=0
//   frame_start_o  one-clk pulse when the new pixel has x=0, y=0
//   pix_ce_o       one-clk pulse in the cycle where outputs take new values
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       pix_ce_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       active_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic       pix_ce_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Position at which each phase begins, and the last slot before wrap.
    localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

    localparam logic [1:0] ST_H_ACT  = 2'd0;
    localparam logic [1:0] ST_H_FP   = 2'd1;
    localparam logic [1:0] ST_H_SYNC = 2'd2;
    localparam logic [1:0] ST_H_BP   = 2'd3;
    localparam logic [1:0] ST_V_ACT  = 2'd0;
    localparam logic [1:0] ST_V_FP   = 2'd1;
    localparam logic [1:0] ST_V_SYNC = 2'd2;
    localparam logic [1:0] ST_V_BP   = 2'd3;

    // Every phase must last at least one slot and the counters are 10 bits.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic       r_started;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [1:0] r_hstate;
    logic [1:0] r_vstate;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_active;
    logic       r_line_start;
    logic       r_frame_start;
    logic       r_pix_ce;

    logic       w_h_wrap;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic [1:0] w_hstate_nxt;
    logic [1:0] w_vstate_nxt;

    // Next position, used only once the generator has started.
    always_comb begin
        w_h_wrap = (r_x == H_LAST);
        w_x_nxt  = w_h_wrap ? 10'd0 : r_x + 10'd1;
        w_y_nxt  = r_y;
        if (w_h_wrap) begin
            w_y_nxt = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
        end
    end

    // Horizontal phase FSM: moves on the ce that brings x to the next phase start.
    always_comb begin
        w_hstate_nxt = r_hstate;
        case (r_hstate)
            ST_H_ACT:  if (w_x_nxt == H_FP_START)   w_hstate_nxt = ST_H_FP;
            ST_H_FP:   if (w_x_nxt == H_SYNC_START) w_hstate_nxt = ST_H_SYNC;
            ST_H_SYNC: if (w_x_nxt == H_BP_START)   w_hstate_nxt = ST_H_BP;
            ST_H_BP:   if (w_x_nxt == 10'd0)        w_hstate_nxt = ST_H_ACT;
            default:                                w_hstate_nxt = ST_H_ACT;
        endcase
    end

    // Vertical phase FSM: only considered on a horizontal wrap.
    always_comb begin
        w_vstate_nxt = r_vstate;
        if (w_h_wrap) begin
            case (r_vstate)
                ST_V_ACT:  if (w_y_nxt == V_FP_START)   w_vstate_nxt = ST_V_FP;
                ST_V_FP:   if (w_y_nxt == V_SYNC_START) w_vstate_nxt = ST_V_SYNC;
                ST_V_SYNC: if (w_y_nxt == V_BP_START)   w_vstate_nxt = ST_V_BP;
                ST_V_BP:   if (w_y_nxt == 10'd0)        w_vstate_nxt = ST_V_ACT;
                default:                                w_vstate_nxt = ST_V_ACT;
            endcase
        end
    end

    // Position, FSMs and all outputs update on the same edge so they never skew.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_started     <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_hstate      <= ST_H_ACT;
            r_vstate      <= ST_V_ACT;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_pix_ce      <= 1'b0;
        end else if (pix_ce_i) begin
            r_pix_ce <= 1'b1;
            if (!r_started) begin
                // First ce presents (0,0) rather than advancing past it.
                r_started     <= 1'b1;
                r_x           <= 10'd0;
                r_y           <= 10'd0;
                r_hstate      <= ST_H_ACT;
                r_vstate      <= ST_V_ACT;
                r_hsync       <= 1'b1;
                r_vsync       <= 1'b1;
                r_active      <= 1'b1;
                r_line_start  <= 1'b1;
                r_frame_start <= 1'b1;
            end else begin
                r_x           <= w_x_nxt;
                r_y           <= w_y_nxt;
                r_hstate      <= w_hstate_nxt;
                r_vstate      <= w_vstate_nxt;
                r_hsync       <= (w_hstate_nxt != ST_H_SYNC);
                r_vsync       <= (w_vstate_nxt != ST_V_SYNC);
                r_active      <= (w_hstate_nxt == ST_H_ACT) && (w_vstate_nxt == ST_V_ACT);
                r_line_start  <= (w_x_nxt == 10'd0);
                r_frame_start <= (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
            end
        end else begin
            // Everything else holds; the marker pulses last a single clk_i.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_pix_ce      <= 1'b0;
        end
    end

    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign active_o      = r_active;
    assign x_o           = r_x;
    assign y_o           = r_y;
    assign line_start_o  = r_line_start;
    assign frame_start_o = r_frame_start;
    assign pix_ce_o      = r_pix_ce;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical equivalents, in lines.
REQ-006 SHALL have port clk_i, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-008 SHALL have port pix_ce_i, input, 1 bit: pixel clock-enable from the clock divider, synchronous to clk_i.
REQ-009 SHALL have port hsync_o, output, 1 bit: horizontal sync, active-low.
REQ-010 SHALL have port vsync_o, output, 1 bit: vertical sync, active-low.
REQ-011 SHALL have port active_o, output, 1 bit: current pixel is visible.
REQ-012 SHALL have port x_o, output, 10 bits: horizontal pixel counter.
REQ-013 SHALL have port y_o, output, 10 bits: vertical line counter.
REQ-014 SHALL have port line_start_o, output, 1 bit: one-clk_i pulse at x=0.
REQ-015 SHALL have port frame_start_o, output, 1 bit: one-clk_i pulse at x=0, y=0.
REQ-016 SHALL have port pix_ce_o, output, 1 bit: one-clk_i pulse marking the clk_i cycle in which the outputs change.

Function
REQ-017 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL likewise (525).
REQ-018 SHALL hold all state and all outputs unchanged in any cycle where pix_ce_i=0.
REQ-019 SHALL hold an internal "started" flag, clear after reset; the first pix_ce_i=1 sets it and presents position (0,0) without incrementing.
REQ-020 SHALL, on each subsequent pix_ce_i=1, increment x; x = H_TOTAL-1 wraps to 0 and increments y; y = V_TOTAL-1 with x wrapping wraps y to 0.
REQ-021 SHALL implement the horizontal sequence as an explicit 4-state FSM H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT.
REQ-022 SHALL take FSM transitions on the pix_ce_i at which x moves to H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC and 0 respectively.
REQ-023 SHALL implement a matching 4-state vertical FSM (V_ACT/V_FP/V_SYNC/V_BP) that advances only on horizontal wrap.
REQ-024 SHALL register every output in the same clk_i edge that updates x/y, so that all outputs describe the same pixel (zero relative skew).
REQ-025 SHALL drive hsync_o=0 iff x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
REQ-026 SHALL drive vsync_o=0 iff y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
REQ-027 SHALL drive active_o=1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-028 SHALL assert line_start_o and pix_ce_o for exactly one clk_i cycle after the triggering edge, even if pix_ce_i is held high continuously.
REQ-029 SHALL assert frame_start_o under the same one-cycle rule, and only at x=0, y=0.
REQ-030 SHALL ensure x_o never exceeds H_TOTAL-1 and y_o never exceeds V_TOTAL-1.
REQ-031 SHALL require each timing parameter to be at least 1 and each total to be at most 1024.

Reset
REQ-032 SHALL, while reset=0, force: x_o=0, y_o=0, hsync_o=1, vsync_o=1, active_o=0, line_start_o=0, frame_start_o=0, pix_ce_o=0, started=0, FSMs to H_ACT/V_ACT.
REQ-033 SHALL respond to reset asynchronously, including mid-line and mid-frame; after release, the first pix_ce_i=1 restarts at (0,0) with frame_start_o=1.

Verification
REQ-034 SHALL verify: reset low, then pix_ce_i=1 -> outputs hold reset values; release reset, first ce -> x=0, y=0, active=1, frame_start=1 and line_start=1 for one clk.
REQ-035 SHALL verify: with defaults, count pix_ce -> hsync_o falls at x=656 and rises at x=752; line length is 800 ces.
REQ-036 SHALL verify: at x=799 then ce -> x=0, y increments, line_start=1; vsync_o low for y=490..491 only; y=524 then wrap -> y=0, frame_start=1.
REQ-037 SHALL verify: pix_ce_i=1 every 4th clk (clock-divider rate) versus pix_ce_i=0 gaps -> outputs frozen between ces, pulses exactly one clk wide.
REQ-038 SHALL verify: with small parameters (2/1/1/1 x 2/1/1/1), run 3 frames -> H_TOTAL=5 and V_TOTAL=5, and full sequence matches a reference model; reset asserted at x=3, y=2 -> immediate return to reset values.
